uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 135 +++++++++++++
 tb/tb_uart_tx_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Four-requester arbiter feeding one UART transmitter: round-robin with per-requester lock and hold limit.
// Optional macro UART_TX_ARB_FIXED_PRIO_EN switches the search to fixed priority (requester 0 highest).
module uart_tx_arb #(
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [7:0]  data_in,
    output logic        en_data_in,
    input  logic        rdy,
    output logic [1:0]  grant_id,
    output logic        busy
);

    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    grant_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [1:0]    tmo_cnt, tmo_nxt;
    logic [3:0]    ack_nxt;
    logic          en_nxt;
    logic [7:0]    data_nxt;

    logic [1:0]    search_start;
    logic [1:0]    rr_pick;
    logic [1:0]    idx;
    logic          found;
    logic          any_req;
    logic          others;
    logic          keep_grant;
    logic [1:0]    arb_winner;

    // Winner selection: a locked holder keeps the grant until it has used up its hold budget
    // while someone else is waiting; otherwise the first pending requester from the search start wins.
    always_comb begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        search_start = 2'd0;
`else
        search_start = grant_id + 2'd1;
`endif
        rr_pick = search_start;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = search_start + i[1:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
        any_req    = |req;
        others     = |(req & ~(4'b0001 << grant_id));
        keep_grant = lock[grant_id] && req[grant_id] && ((hold_cnt < HOLD_LIM) || !others);
        arb_winner = keep_grant ? grant_id : rr_pick;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        hold_nxt  = hold_cnt;
        tmo_nxt   = tmo_cnt;
        ack_nxt   = 4'b0000;
        en_nxt    = 1'b0;
        data_nxt  = data_in;
        case (state)
            IDLE: begin
                if (any_req && rdy) begin
                    grant_nxt = arb_winner;
                    if (arb_winner != grant_id) hold_nxt = '0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                tmo_nxt = 2'd0;
                // A requester that withdrew before its byte was taken gets nothing.
                if (req[grant_id]) begin
                    ack_nxt  = 4'b0001 << grant_id;
                    en_nxt   = 1'b1;
                    data_nxt = req_data[{grant_id, 3'b000} +: 8];
                    if (hold_cnt != HOLD_LIM) hold_nxt = hold_cnt + 1'b1;
                    state_nxt = WAIT_BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (!rdy || tmo_cnt == 2'd3) state_nxt = WAIT_DONE;
                else                         tmo_nxt   = tmo_cnt + 2'd1;
            end
            WAIT_DONE: begin
                if (rdy) begin
                    if (any_req) begin
                        grant_nxt = arb_winner;
                        if (arb_winner != grant_id) hold_nxt = '0;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= IDLE;
            grant_id   <= 2'd3;
            hold_cnt   <= '0;
            tmo_cnt    <= 2'd0;
            ack        <= 4'b0000;
            en_data_in <= 1'b0;
            data_in    <= 8'h00;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            hold_cnt   <= hold_nxt;
            tmo_cnt    <= tmo_nxt;
            ack        <= ack_nxt;
            en_data_in <= en_nxt;
            data_in    <= data_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: transmitter model, ack monitor and hand-computed expectations.
module tb_uart_tx_arb;

    logic        clk;
    logic        res;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  data_in;
    logic        en_data_in;
    logic        rdy;
    logic [1:0]  grant_id;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    int         ack_idx_q[$];
    logic [7:0] ack_data_q[$];
    int         ack_cyc_q[$];
    int         cyc = 0;
    int         multi_ack_err = 0;
    int         en_b2b_err = 0;
    int         en_noack_err = 0;
    logic       en_prev = 1'b0;

    int         tx_cnt = 0;
    logic       tx_tied = 1'b0;
    int         cnt2;
    int         gap;

    uart_tx_arb #(.HOLD_MAX(16)) dut (
        .clk        (clk),
        .res        (res),
        .req        (req),
        .lock       (lock),
        .req_data   (req_data),
        .ack        (ack),
        .data_in    (data_in),
        .en_data_in (en_data_in),
        .rdy        (rdy),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter: goes busy for 10 cycles after each load strobe unless tied idle.
    initial begin
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) rdy = 1'b1;
            end else if (en_data_in && !tx_tied) begin
                rdy    = 1'b0;
                tx_cnt = 10;
            end
        end
    end

    // Records every ack and watches for protocol violations.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack != 4'b0000) begin
                if ($countones(ack) != 1) multi_ack_err++;
                for (int k = 0; k < 4; k++)
                    if (ack[k]) begin
                        ack_idx_q.push_back(k);
                        ack_data_q.push_back(data_in);
                        ack_cyc_q.push_back(cyc);
                        break;
                    end
            end
            if (en_data_in && en_prev) en_b2b_err++;
            if (en_data_in && ack == 4'b0000) en_noack_err++;
            en_prev = en_data_in;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h required %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        lock = l;
    endtask

    task automatic clearLog();
        ack_idx_q.delete();
        ack_data_q.delete();
        ack_cyc_q.delete();
    endtask

    task automatic resetDut();
        applyStimulus(4'b0000, 4'b0000);
        tick(12);
        res = 1'b1;
        tick(2);
        res = 1'b0;
        clearLog();
    endtask

    task automatic waitAcks(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (ack_idx_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        checkOutput(tag, ack_idx_q.size(), n);
    endtask

    initial begin
        res      = 1'b1;
        req      = 4'b0000;
        lock     = 4'b0000;
        req_data = 32'h0;

        // Reset values while reset is held
        tick(2);
        checkOutput("rst_ack", ack, 4'b0000);
        checkOutput("rst_en", en_data_in, 1'b0);
        checkOutput("rst_data", data_in, 8'h00);
        checkOutput("rst_grant", grant_id, 2'd3);
        checkOutput("rst_busy", busy, 1'b0);
        res = 1'b0;
        clearLog();

        // Single byte: LOAD one cycle after req, strobe/ack the cycle after, data held afterwards
        req_data = 32'h0000_0055;
        applyStimulus(4'b0001, 4'b0000);
        tick(1);
        checkOutput("load_busy", busy, 1'b1);
        checkOutput("load_grant", grant_id, 2'd0);
        checkOutput("load_en_early", en_data_in, 1'b0);
        tick(1);
        checkOutput("first_ack", ack, 4'b0001);
        checkOutput("first_en", en_data_in, 1'b1);
        checkOutput("first_data", data_in, 8'h55);
        applyStimulus(4'b0000, 4'b0000);
        tick(1);
        checkOutput("ack_pulse", ack, 4'b0000);
        checkOutput("en_pulse", en_data_in, 1'b0);
        checkOutput("data_hold", data_in, 8'h55);

        // Requester drops req before its byte is taken
        resetDut();
        applyStimulus(4'b0001, 4'b0000);
        tick(1);
        applyStimulus(4'b0000, 4'b0000);
        tick(1);
        checkOutput("drop_ack", ack, 4'b0000);
        checkOutput("drop_en", en_data_in, 1'b0);
        checkOutput("drop_busy", busy, 1'b0);
        tick(3);
        checkOutput("drop_nlog", ack_idx_q.size(), 0);

        // Round robin across all four requesters
        resetDut();
        req_data = 32'hD3C2_B1A0;
        applyStimulus(4'b1111, 4'b0000);
        waitAcks(5, 200, "rr_count");
        checkOutput("rr_0", ack_idx_q[0], 0);
        checkOutput("rr_1", ack_idx_q[1], 1);
        checkOutput("rr_2", ack_idx_q[2], 2);
        checkOutput("rr_3", ack_idx_q[3], 3);
        checkOutput("rr_4", ack_idx_q[4], 0);
        checkOutput("rr_d0", ack_data_q[0], 8'hA0);
        checkOutput("rr_d1", ack_data_q[1], 8'hB1);
        checkOutput("rr_d2", ack_data_q[2], 8'hC2);
        checkOutput("rr_d3", ack_data_q[3], 8'hD3);

        // Requesters 0 and 3 pending
        resetDut();
        applyStimulus(4'b1001, 4'b0000);
        waitAcks(4, 200, "prio_count");
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        checkOutput("prio_0", ack_idx_q[0], 0);
        checkOutput("prio_1", ack_idx_q[1], 0);
        checkOutput("prio_2", ack_idx_q[2], 0);
        checkOutput("prio_3", ack_idx_q[3], 0);
`else
        checkOutput("prio_0", ack_idx_q[0], 0);
        checkOutput("prio_1", ack_idx_q[1], 3);
        checkOutput("prio_2", ack_idx_q[2], 0);
        checkOutput("prio_3", ack_idx_q[3], 3);
`endif

        // Lock with hold limit: grant last at 1, so requester 2 wins, keeps 16 bytes, then rotates to 1
        resetDut();
        applyStimulus(4'b0010, 4'b0000);
        waitAcks(1, 50, "lock_pre");
        checkOutput("lock_pre_id", ack_idx_q[0], 1);
        applyStimulus(4'b0000, 4'b0000);
        cnt2 = 0;
        while (busy && cnt2 < 40) begin
            tick(1);
            cnt2++;
        end
        checkOutput("lock_idle", busy, 1'b0);
        clearLog();
        applyStimulus(4'b0110, 4'b0100);
        waitAcks(17, 400, "lock_count");
        cnt2 = 0;
        for (int k = 0; k < 16; k++)
            if (ack_idx_q[k] == 2) cnt2++;
        checkOutput("lock_run2", cnt2, 16);
        checkOutput("lock_rotate", ack_idx_q[16], 1);
        applyStimulus(4'b0000, 4'b0000);

        // Transmitter never answers: WAIT_BUSY times out, next byte follows 6 cycles later
        resetDut();
        tx_tied = 1'b1;
        applyStimulus(4'b0001, 4'b0000);
        waitAcks(3, 60, "tmo_count");
        gap = ack_cyc_q[1] - ack_cyc_q[0];
        checkOutput("tmo_gap1", gap, 6);
        gap = ack_cyc_q[2] - ack_cyc_q[1];
        checkOutput("tmo_gap2", gap, 6);
        applyStimulus(4'b0000, 4'b0000);
        tx_tied = 1'b0;

        // Reset while waiting for the transmitter; arbitration restarts at requester 0
        resetDut();
        applyStimulus(4'b0011, 4'b0000);
        waitAcks(1, 50, "rmid_first");
        checkOutput("rmid_first_id", ack_idx_q[0], 0);
        tick(3);
        checkOutput("rmid_busy_pre", busy, 1'b1);
        res = 1'b1;
        tick(1);
        checkOutput("rmid_busy", busy, 1'b0);
        checkOutput("rmid_ack", ack, 4'b0000);
        checkOutput("rmid_en", en_data_in, 1'b0);
        checkOutput("rmid_grant", grant_id, 2'd3);
        res = 1'b0;
        clearLog();
        waitAcks(1, 50, "rmid_next");
        checkOutput("rmid_next_id", ack_idx_q[0], 0);
        applyStimulus(4'b0000, 4'b0000);
        tick(15);

        checkOutput("multi_ack", multi_ack_err, 0);
        checkOutput("en_b2b", en_b2b_err, 0);
        checkOutput("en_noack", en_noack_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
